// File: rtl/bcd_pkg.sv
// Shared definitions for the excess-3 -> BCD converter and the digit packer.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX     = 4'd9;
  localparam bcd_digit_t EXS3_OFFSET = 4'd3;

  typedef enum logic [1:0] {PK_IDLE, PK_COLLECT, PK_HOLD} pk_state_t;
endpackage

// File: rtl/bcd_digit_check.sv
// Flags a 4-bit code that is not a legal BCD digit (10..15).
module bcd_digit_check
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output logic       illegal
);
  assign illegal = (digit > BCD_MAX);
endmodule

// File: rtl/bcd_digit_packer.sv
// Packs a frame of up to NUM_DIGITS BCD digits (MSD first) into one right-aligned
// word and presents it over valid/ready, with an illegal-digit flag per frame.
module bcd_digit_packer
  import bcd_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  localparam int CW         = $clog2(NUM_DIGITS + 1),
  localparam int W          = 4 * NUM_DIGITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  bcd_digit_t    in_digit,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bcd,
  output logic [CW-1:0] out_ndig,
  output logic          out_err
);

  pk_state_t     state, state_nxt;
  logic [W-1:0]  shreg, shreg_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          err_acc, err_nxt;
  logic          illegal, accept, close;

  bcd_digit_check u_check (
    .digit   (in_digit),
    .illegal (illegal)
  );

  assign accept    = in_valid & in_ready;
  assign shreg_nxt = {shreg[W-5:0], in_digit};
  assign count_nxt = count + CW'(1);
  assign err_nxt   = err_acc | illegal;
  // A full frame closes regardless of in_last; the next digit opens a new one.
  assign close     = accept & (in_last | (count == CW'(NUM_DIGITS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PK_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PK_IDLE, PK_COLLECT: if (accept) state_nxt = close ? PK_HOLD : PK_COLLECT;
      PK_HOLD:             if (out_ready) state_nxt = PK_IDLE;
      default:             state_nxt = PK_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so the source sees no acceptance while reset is held.
  always_comb begin
    in_ready  = rst_n & (state != PK_HOLD);
    out_valid = (state == PK_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      count    <= '0;
      err_acc  <= 1'b0;
      out_bcd  <= '0;
      out_ndig <= '0;
      out_err  <= 1'b0;
    end else if (accept) begin
      shreg   <= shreg_nxt;
      count   <= count_nxt;
      err_acc <= err_nxt;
      if (close) begin
        out_bcd  <= shreg_nxt;
        out_ndig <= count_nxt;
        out_err  <= err_nxt;
      end
    end else if (state == PK_HOLD && out_ready) begin
      // Word is gone; output regs keep the last word for observability.
      shreg   <= '0;
      count   <= '0;
      err_acc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_digit_packer.sv
// Randomized + directed bench for bcd_digit_packer against a frame-level reference model.
module tb_bcd_digit_packer;
  localparam int ND = 4;
  localparam int CW = $clog2(ND + 1);

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [3:0]    in_digit = 0;
  logic          in_last = 0;
  logic          out_valid;
  logic          out_ready;
  logic [4*ND-1:0] out_bcd;
  logic [CW-1:0] out_ndig;
  logic          out_err;

  logic rand_rdy = 0, rnd_rdy = 0, fix_rdy = 1;
  assign out_ready = rand_rdy ? rnd_rdy : fix_rdy;

  int n_chk = 0, n_err = 0;

  bcd_digit_packer #(.NUM_DIGITS(ND)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_bcd(out_bcd), .out_ndig(out_ndig), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a list of held digits and at most one pending word.
  int   q[$];
  bit   pend = 0;
  int   m_word = 0, m_ndig = 0, words = 0;
  bit   m_err = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_bcd", out_bcd, 0);
      chk("rst_ndig", out_ndig, 0);
      chk("rst_err", out_err, 0);
      q.delete(); pend = 0; m_word = 0; m_ndig = 0; m_err = 0;
    end else begin
      chk("in_ready", in_ready, !pend);
      chk("out_valid", out_valid, pend);
      chk("out_bcd", out_bcd, m_word);
      chk("out_ndig", out_ndig, m_ndig);
      chk("out_err", out_err, m_err);
      if (pend) begin
        if (out_ready) begin pend = 0; words++; end
      end else if (in_valid) begin
        q.push_back(int'(in_digit));
        if (in_last || q.size() == ND) begin
          m_word = 0; m_err = 0;
          foreach (q[i]) begin
            m_word = m_word * 16 + q[i];
            if (q[i] > 9) m_err = 1;
          end
          m_ndig = q.size();
          pend = 1;
          q.delete();
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Drives one digit and holds it until accepted; returns cycles spent.
  task automatic send(input logic [3:0] d, input logic last, output int waits);
    bit acc = 0;
    waits = 0;
    in_valid = 1; in_digit = d; in_last = last;
    while (!acc && waits < 100) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      waits++;
    end
    chk("accept_timeout", acc, 1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int w, w0;
    logic [15:0] held;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    idle(2);

    // 1: reset mid-COLLECT
    send(4'd3, 0, w); send(4'd8, 0, w);
    rst_n = 0;
    @(negedge clk);
    chk("t1_ready", in_ready, 0); chk("t1_valid", out_valid, 0); chk("t1_bcd", out_bcd, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("t1_idle_ready", in_ready, 1);
    @(posedge clk); #1;

    // 2: full frame, no in_last
    fix_rdy = 1;
    send(4'd1, 0, w); send(4'd2, 0, w); send(4'd3, 0, w); send(4'd4, 0, w);
    @(negedge clk);
    chk("t2_valid", out_valid, 1); chk("t2_bcd", out_bcd, 16'h1234);
    chk("t2_ndig", out_ndig, 4); chk("t2_err", out_err, 0); chk("t2_bubble", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("t2_idle", in_ready, 1); chk("t2_keep", out_bcd, 16'h1234);
    @(posedge clk); #1;

    // 3: short frame
    send(4'd7, 0, w); send(4'd9, 1, w);
    @(negedge clk);
    chk("t3_bcd", out_bcd, 16'h0079); chk("t3_ndig", out_ndig, 2); chk("t3_err", out_err, 0);
    @(posedge clk); #1;

    // 4: illegal digit, not sticky
    send(4'd1, 0, w); send(4'hA, 0, w); send(4'd3, 0, w); send(4'd4, 0, w);
    @(negedge clk); chk("t4_bcd", out_bcd, 16'h1A34); chk("t4_err", out_err, 1);
    @(posedge clk); #1;
    send(4'd5, 0, w); send(4'd6, 0, w); send(4'd7, 0, w); send(4'd8, 0, w);
    @(negedge clk); chk("t4b_bcd", out_bcd, 16'h5678); chk("t4b_err", out_err, 0);
    @(posedge clk); #1;

    // 5: backpressure in HOLD
    fix_rdy = 0;
    send(4'd5, 0, w); send(4'd5, 1, w);
    in_valid = 1; in_digit = 4'd2; in_last = 1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_ready", in_ready, 0); chk("t5_stable", out_bcd, 16'h0055); chk("t5_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    fix_rdy = 1;
    send(4'd2, 1, w);
    chk("t5_waits", w, 2);
    @(negedge clk); chk("t5_bcd", out_bcd, 16'h0002);
    @(posedge clk); #1;

    // 6: back-to-back single-digit frames, random out_ready
    idle(2);
    rand_rdy = 1;
    w0 = words;
    for (int i = 0; i < 20; i++) send(4'($urandom_range(0, 9)), 1, w);
    for (int i = 0; i < 100 && pend; i++) idle(1);
    chk("t6_words", words - w0, 20);

    // random frames with gaps and occasional reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 0; idle(1); rst_n = 1;
      end
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), w);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    for (int i = 0; i < 100 && pend; i++) idle(1);
    rand_rdy = 0; fix_rdy = 1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
